slave_port: RTL

- Responder end of the serial system bus. Pairs with the master-side port: deserialises the 16-bit address and write data, drives `ack`, `slave_ready`, `slave_valid`, `rd_bus` and `split`, and serialises read data.
- Sits between the bus interconnect and one local 8-bit memory. Decodes its own device select and runs single-byte read/write cycles on the memory side.

---
 rtl/slave_port_if.sv | 38 +++
 rtl/slave_port.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port_if.sv
// slave_port_if: serial system bus between the master-side port and slave_port.
interface slave_port_if;
    logic mode;
    logic wr_bus;
    logic master_valid;
    logic slave_ready;
    logic rd_bus;
    logic slave_valid;
    logic master_ready;
    logic ack;
    logic split;

    // Requester end: drives address/write bits and accepts read bits
    modport master (
        output mode,
        output wr_bus,
        output master_valid,
        output master_ready,
        input  slave_ready,
        input  rd_bus,
        input  slave_valid,
        input  ack,
        input  split
    );

    // Responder end: deserialises the request and serialises read data
    modport slave (
        input  mode,
        input  wr_bus,
        input  master_valid,
        input  master_ready,
        output slave_ready,
        output rd_bus,
        output slave_valid,
        output ack,
        output split
    );
endinterface

// File: rtl/slave_port.sv
// slave_port: responder end of the serial system bus. Receives a 16-bit
// address (device select in [15:12]) and optional write byte MSB first, runs a
// single-byte access on the local memory and serialises read data back.
module slave_port #(
    parameter logic [3:0]  DEVICE_ID  = 4'h1,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned SPLIT_WAIT = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    slave_port_if.slave       bus,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [7:0]        s_wr_data_o,
    output logic              s_wr_en_o,
    output logic              s_rd_en_o,
    input  logic [7:0]        s_rd_data_i,
    input  logic              s_rd_valid_i
);

    localparam int unsigned WAIT_W = $clog2(SPLIT_WAIT + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT);
    localparam int unsigned BIT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WDATA  = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_MEM_RD = 3'd4,
        ST_RDATA  = 3'd5,
        ST_DROP   = 3'd6
    } state_e;

    state_e            state_q;
    logic              mode_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [15:0]       addr_sh_q;
    logic [7:0]        wdata_sh_q;
    logic [7:0]        rdata_sh_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              ack_q;
    logic              split_q;
    logic              slave_ready_q;
    logic              slave_valid_q;
    logic              s_wr_en_q;
    logic              s_rd_en_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic [7:0]        s_wr_data_q;

    logic              in_xfer_c;
    logic              out_xfer_c;
    logic              to_hit_c;
    logic              sel_hit_c;
    logic              split_hit_c;
    logic              wait_sat_c;
    logic [15:0]       addr_sh_d;
    logic [7:0]        wdata_sh_d;

    // Handshake qualifiers and shifted candidates for the incoming bit
    assign in_xfer_c   = bus.master_valid & slave_ready_q;
    assign out_xfer_c  = slave_valid_q & bus.master_ready;
    assign addr_sh_d   = {addr_sh_q[14:0], bus.wr_bus};
    assign wdata_sh_d  = {wdata_sh_q[6:0], bus.wr_bus};
    assign sel_hit_c   = (addr_sh_d[3:0] == DEVICE_ID);
    assign to_hit_c    = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign split_hit_c = (wait_cnt_q == WAIT_W'(SPLIT_WAIT - 1));
    assign wait_sat_c  = (wait_cnt_q == WAIT_W'(SPLIT_WAIT));

    // Transaction FSM; every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= 1'b0;
            bit_cnt_q     <= '0;
            addr_sh_q     <= '0;
            wdata_sh_q    <= '0;
            rdata_sh_q    <= '0;
            wait_cnt_q    <= '0;
            to_cnt_q      <= '0;
            ack_q         <= 1'b0;
            split_q       <= 1'b0;
            slave_ready_q <= 1'b0;
            slave_valid_q <= 1'b0;
            s_wr_en_q     <= 1'b0;
            s_rd_en_q     <= 1'b0;
            s_addr_q      <= '0;
            s_wr_data_q   <= '0;
        end else begin
            s_wr_en_q <= 1'b0;
            s_rd_en_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    slave_ready_q <= 1'b1;
                    slave_valid_q <= 1'b0;
                    ack_q         <= 1'b0;
                    split_q       <= 1'b0;
                    to_cnt_q      <= '0;
                    wait_cnt_q    <= '0;
                    if (in_xfer_c) begin
                        addr_sh_q <= addr_sh_d;
                        mode_q    <= bus.mode;
                        bit_cnt_q <= BIT_W'(1);
                        state_q   <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (in_xfer_c) begin
                        to_cnt_q  <= '0;
                        addr_sh_q <= addr_sh_d;
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(3)) begin
                            // Device select is complete once bits [15:12] are in
                            if (sel_hit_c) begin
                                ack_q <= 1'b1;
                            end else begin
                                slave_ready_q <= 1'b0;
                                state_q       <= ST_DROP;
                            end
                        end else if (bit_cnt_q == BIT_W'(15)) begin
                            s_addr_q <= addr_sh_d[ADDR_W-1:0];
                            if (mode_q) begin
                                state_q <= ST_WDATA;
                            end else begin
                                slave_ready_q <= 1'b0;
                                s_rd_en_q     <= 1'b1;
                                wait_cnt_q    <= '0;
                                state_q       <= ST_MEM_RD;
                            end
                        end
                    end else if (to_hit_c) begin
                        ack_q    <= 1'b0;
                        to_cnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                ST_WDATA: begin
                    if (in_xfer_c) begin
                        to_cnt_q   <= '0;
                        wdata_sh_q <= wdata_sh_d;
                        bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(7)) begin
                            bit_cnt_q     <= '0;
                            s_wr_data_q   <= wdata_sh_d;
                            s_wr_en_q     <= 1'b1;
                            slave_ready_q <= 1'b0;
                            state_q       <= ST_MEM_WR;
                        end
                    end else if (to_hit_c) begin
                        ack_q    <= 1'b0;
                        to_cnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                ST_MEM_WR: begin
                    ack_q         <= 1'b0;
                    slave_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end

                ST_MEM_RD: begin
                    if (s_rd_valid_i) begin
                        rdata_sh_q    <= s_rd_data_i;
                        split_q       <= 1'b0;
                        slave_valid_q <= 1'b1;
                        bit_cnt_q     <= '0;
                        state_q       <= ST_RDATA;
                    end else if (!wait_sat_c) begin
                        // Saturating wait counter; split marks a slow memory
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                        if (split_hit_c) begin
                            split_q <= 1'b1;
                        end
                    end
                end

                ST_RDATA: begin
                    if (out_xfer_c) begin
                        rdata_sh_q <= {rdata_sh_q[6:0], 1'b0};
                        bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(7)) begin
                            bit_cnt_q     <= '0;
                            slave_valid_q <= 1'b0;
                            slave_ready_q <= 1'b1;
                            ack_q         <= 1'b0;
                            state_q       <= ST_IDLE;
                        end
                    end
                end

                ST_DROP: begin
                    // Ignore the rest of a foreign transfer until the master lets go
                    if (!bus.master_valid) begin
                        slave_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end

                default: begin
                    slave_ready_q <= 1'b0;
                    slave_valid_q <= 1'b0;
                    ack_q         <= 1'b0;
                    split_q       <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    // Output wiring straight from registers
    assign bus.slave_ready = slave_ready_q;
    assign bus.slave_valid = slave_valid_q;
    assign bus.rd_bus      = rdata_sh_q[7];
    assign bus.ack         = ack_q;
    assign bus.split       = split_q;
    assign s_addr_o        = s_addr_q;
    assign s_wr_data_o     = s_wr_data_q;
    assign s_wr_en_o       = s_wr_en_q;
    assign s_rd_en_o       = s_rd_en_q;

endmodule
